exidy_tone_bank: RTL
====================

EXIDY_TONE_BANK -- requirements
Module: exidy_tone_bank

Interface
REQ-001 SHALL provide parameter CHANNELS, default 3, number of tone channels (1..4).
REQ-002 SHALL provide parameter CNT_W, default 8, period/counter width (4..8).
REQ-003 SHALL provide parameter PRE_W, default 8, prescaler width.
REQ-004 SHALL provide parameter PRE_LOAD, default 8'hB9, prescaler reload value.
REQ-005 SHALL provide parameter OUT_W, default 16, mix output width (>= 4+clog2(CHANNELS)).
REQ-006 SHALL provide ports:
- audio_clk  in  1  sole clock, rising edge.
- RESET_n  in  1  reset, asynchronous, active-low.
- cen  in  1  clock enable; all counting advances only when high.
- wr  in  1  register write strobe; sampled on every audio_clk, independent of cen.
- addr  in  4  {channel[1:0], reg[1:0]}.
- din  in  8  write data.
- dout  out  8  readback of addressed register.
- pause  in  1  mute.
- tone  out  CHANNELS  per-channel square/pulse bit.
- mix  out  OUT_W  unsigned mixed sample.

Function
REQ-007 SHALL decode reg 0=period[CNT_W-1:0], 1=control {bit0 EN, bit1 ONESHOT, bit7 DONE (read-only)}, 2=volume[3:0], 3=reserved (writes ignored, reads 0).
REQ-008 SHALL ignore writes and return 0 on reads when channel index >= CHANNELS.
REQ-009 SHALL run one shared prescaler: on cen, when at all-ones reload PRE_LOAD and assert tick for that cen cycle; otherwise increment.
REQ-010 SHALL, on tick, advance each enabled channel counter: at all-ones, reload from period and toggle tone; otherwise increment.
REQ-011 SHALL produce a tone half-period of (2^CNT_W - period) ticks; period all-ones toggles every tick.
REQ-012 SHALL apply a period write to a running channel at its next reload only.
REQ-013 SHALL, on a control write changing EN from 0 to 1, load the counter from period, clear tone, and clear DONE in the same cycle.
REQ-014 SHALL, while EN=0, hold the counter and force tone low.
REQ-015 SHALL, in ONESHOT mode, drive tone high from enable until the first terminal count, then drive tone low, clear EN, and set DONE.
REQ-016 SHALL give a control write priority over a simultaneous terminal count on the same channel.
REQ-017 SHALL resolve a period write coinciding with a reload by reloading the newly written value.
REQ-018 SHALL register mix on cen as the zero-extended sum of volume for every channel whose tone is high.
REQ-019 SHALL force mix to 0 on the next cen while pause is high, without stopping counters.
REQ-020 SHALL return dout combinationally from addr, zero-extended.

Reset
REQ-021 SHALL, while RESET_n is low, set prescaler to PRE_LOAD, all counters, periods, volumes, EN, ONESHOT, DONE, tone and mix to 0, independent of audio_clk.
REQ-022 SHALL resume counting on the first cen after RESET_n deasserts; reset mid-tone SHALL truncate the tone immediately.

Verification
REQ-023 Defaults, cen always 1, ch0 period=FE, vol=F, EN=1 -> tone[0] toggles every 142 cycles (71-cycle tick); mix alternates 0/15.
REQ-024 ch0 ONESHOT=1, period=F0, EN=1 -> tone[0] high 16 ticks then low; control reads 8'h80.
REQ-025 Three channels vol 4/5/6, all tones high -> mix=15; pause=1 -> mix=0 next cen, tones keep toggling.
REQ-026 Write period=80 on the same cycle ch0 reaches FF on tick -> counter reloads 80, next half-period 128 ticks.
REQ-027 Pulse RESET_n low mid-tone without a clock edge -> tone, mix, and registers read 0 immediately.
REQ-028 CHANNELS=2, write addr=4'hC (ch3) -> no state change; dout reads 0.

Source files
------------

// File: rtl/exidy_tone_bank_if.sv
// exidy_tone_bank_if -- register bus for the tone bank.
//
// Signals:
//   wr    write strobe, one register write per audio_clk edge it is high on
//   addr  {channel[1:0], reg[1:0]}
//   din   write data
//   dout  combinational readback of the register selected by addr
//
// Bus semantics: there is no valid/ready pair. A write is accepted on every
// rising audio_clk edge where wr is high, regardless of cen, and it always
// completes in that edge (the slave never stalls). Reads have no strobe: dout
// follows addr combinationally in the same cycle.
interface exidy_tone_bank_if;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output wr, output addr, output din, input dout);
  modport slave  (input wr, input addr, input din, output dout);
endinterface

// File: rtl/exidy_tone_bank.sv
// exidy_tone_bank -- bank of programmable square/pulse tone channels with a
// shared prescaler and a volume-weighted mixer.
//
// Ports:
//   audio_clk  sole clock, rising edge
//   RESET_n    asynchronous active-low reset
//   cen        clock enable for prescaler, channel counters and mixer
//   pause      mute: mixer output forced to 0 while high (counters keep running)
//   bus        register bus (wr/addr/din/dout), slave side
//   tone       per-channel tone bit
//   mix        unsigned sum of the volumes of all channels whose tone is high
//
// Register map per channel (addr = {channel, reg}):
//   0  period[CNT_W-1:0]
//   1  control {bit7 DONE (read-only), bit1 ONESHOT, bit0 EN}
//   2  volume[3:0]
//   3  reserved, reads 0
// Channels at or above CHANNELS ignore writes and read 0.
module exidy_tone_bank #(
  parameter int               CHANNELS = 3,
  parameter int               CNT_W    = 8,
  parameter int               PRE_W    = 8,
  parameter logic [PRE_W-1:0] PRE_LOAD = 8'hB9,
  parameter int               OUT_W    = 16
) (
  input  logic                audio_clk,
  input  logic                RESET_n,
  input  logic                cen,
  input  logic                pause,
  exidy_tone_bank_if.slave    bus,
  output logic [CHANNELS-1:0] tone,
  output logic [OUT_W-1:0]    mix
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    cnt_d    [CHANNELS];
  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CNT_W-1:0]    period_d [CHANNELS];
  logic [3:0]          vol_q    [CHANNELS];
  logic [3:0]          vol_d    [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] os_q, os_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] tone_q, tone_d;
  logic [OUT_W-1:0]    mix_q, mix_d;

  logic                tick;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [1:0] a_ch;
  logic [1:0] a_reg;
  logic       a_ok;

  assign a_ch  = bus.addr[3:2];
  assign a_reg = bus.addr[1:0];
  // Widened by one bit so CHANNELS=4 still compares correctly.
  assign a_ok  = ({1'b0, a_ch} < 3'(CHANNELS));

  logic [CHANNELS-1:0] wr_per;
  logic [CHANNELS-1:0] wr_ctl;
  logic [CHANNELS-1:0] wr_vol;

  always_comb begin
    wr_per = '0;
    wr_ctl = '0;
    wr_vol = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.wr && a_ok && (int'(a_ch) == c)) begin
        wr_per[c] = (a_reg == 2'd0);
        wr_ctl[c] = (a_reg == 2'd1);
        wr_vol[c] = (a_reg == 2'd2);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shared prescaler: counts up from PRE_LOAD; the cen cycle that finds it at
  // all-ones is the tick, and it reloads on that same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (cen) begin
      if (&pre_q) begin
        pre_d = PRE_LOAD;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel next-state
  // ---------------------------------------------------------------------
  always_comb begin
    en_d   = en_q;
    os_d   = os_q;
    done_d = done_q;
    tone_d = tone_q;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c]    = cnt_q[c];
      period_d[c] = period_q[c];
      vol_d[c]    = vol_q[c];

      // period_d is used as the reload source below, so a period write landing
      // on the reload cycle is picked up immediately.
      if (wr_per[c]) begin
        period_d[c] = bus.din[CNT_W-1:0];
      end
      if (wr_vol[c]) begin
        vol_d[c] = bus.din[3:0];
      end

      if (wr_ctl[c]) begin
        // A control write owns the channel for this cycle; any terminal count
        // that coincides with it is discarded.
        en_d[c] = bus.din[0];
        os_d[c] = bus.din[1];
        if (bus.din[0] && !en_q[c]) begin
          // Fresh start: a one-shot pulse begins high, a square wave begins low.
          cnt_d[c]  = period_q[c];
          tone_d[c] = bus.din[1];
          done_d[c] = 1'b0;
        end else if (!bus.din[0]) begin
          tone_d[c] = 1'b0;
        end
      end else if (tick && en_q[c]) begin
        if (&cnt_q[c]) begin
          cnt_d[c] = period_d[c];
          if (os_q[c]) begin
            // One-shot is consumed: the channel returns to idle with only
            // DONE left set.
            tone_d[c] = 1'b0;
            en_d[c]   = 1'b0;
            os_d[c]   = 1'b0;
            done_d[c] = 1'b1;
          end else begin
            tone_d[c] = ~tone_q[c];
          end
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Disabled channels are always silent, whatever tone_q holds.
  assign tone = tone_q & en_q;

  // ---------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] vol_sum;

  always_comb begin
    vol_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tone[c]) begin
        vol_sum = vol_sum + OUT_W'(vol_q[c]);
      end
    end
  end

  always_comb begin
    mix_d = mix_q;
    if (cen) begin
      mix_d = pause ? '0 : vol_sum;
    end
  end

  assign mix = mix_q;

  // ---------------------------------------------------------------------
  // Readback
  // ---------------------------------------------------------------------
  always_comb begin
    bus.dout = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (a_ok && (int'(a_ch) == c)) begin
        case (a_reg)
          2'd0:    bus.dout = 8'(period_q[c]);
          2'd1:    bus.dout = {done_q[c], 5'b00000, os_q[c], en_q[c]};
          2'd2:    bus.dout = {4'h0, vol_q[c]};
          default: bus.dout = 8'h00;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge audio_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      pre_q  <= PRE_LOAD;
      en_q   <= '0;
      os_q   <= '0;
      done_q <= '0;
      tone_q <= '0;
      mix_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= '0;
        period_q[c] <= '0;
        vol_q[c]    <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      en_q   <= en_d;
      os_q   <= os_d;
      done_q <= done_d;
      tone_q <= tone_d;
      mix_q  <= mix_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
        vol_q[c]    <= vol_d[c];
      end
    end
  end

endmodule
